// File: rtl/playseq_motor_sequencia.sv
// rtl/playseq_motor_sequencia.sv - PlaySeq record/playback sequence engine with internal RAM and timers
module playseq_motor_sequencia #(
  parameter  int N_BOTOES = 4,
  parameter  int PROF     = 16,
  parameter  int T_LED    = 500,
  parameter  int T_JOGADA = 5000,
  localparam int AW       = $clog2(PROF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                gravar,
  input  logic                confirma,
  input  logic                jogar,
  input  logic [AW:0]         inicio,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [AW:0]         comprimento,
  output logic [AW:0]         rodada,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_endereco
);

  localparam int TMAX = (T_LED > T_JOGADA) ? T_LED : T_JOGADA;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LED_FIM = TW'(T_LED - 1);
  localparam logic [TW-1:0] JOG_FIM = TW'(T_JOGADA - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    GRAVA_ESPERA   = 4'd1,
    GRAVA_ESCREVE  = 4'd2,
    MOSTRA_ACESO   = 4'd3,
    MOSTRA_APAGADO = 4'd4,
    ESPERA_JOGADA  = 4'd5,
    COMPARA        = 4'd6,
    PROX_RODADA    = 4'd7,
    ACERTO         = 4'd8,
    ERRO           = 4'd9,
    TIMEOUT        = 4'd10
  } estado_t;

  estado_t             r_estado;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       r_addr;
  logic [TW-1:0]       r_timer;
  logic [AW:0]         r_comprimento;
  logic [AW:0]         r_rodada;
  logic                r_or_prev;
  logic                r_press;
  logic [N_BOTOES-1:0] r_cap;
  logic                r_conf_pend;
  logic [N_BOTOES-1:0] r_mem [PROF];
  logic [N_BOTOES-1:0] r_dout;

  logic                w_rise;
  logic                w_onehot;
  logic [AW:0]         w_addr_inc;
  logic                w_ha_mais;
  logic [AW:0]         w_ptr_inc;
  logic [AW:0]         w_l0;
  logic [AW:0]         w_rodada0;
  logic [AW-1:0]       w_rd_addr;

  assign w_rise     = (|botoes) & ~r_or_prev;
  assign w_onehot   = (r_cap != '0) && ((r_cap & (r_cap - N_BOTOES'(1))) == '0);
  assign w_addr_inc = {1'b0, r_addr} + (AW+1)'(1);
  assign w_ha_mais  = w_addr_inc < r_rodada;
  assign w_ptr_inc  = {1'b0, r_ptr} + (AW+1)'(1);
  assign w_l0       = (inicio == '0) ? (AW+1)'(1) : inicio;
  assign w_rodada0  = (w_l0 > r_comprimento) ? r_comprimento : w_l0;

  // RAM read address anticipates the next r_addr so data is ready on the first lit cycle
  always_comb begin
    w_rd_addr = r_addr;
    case (r_estado)
      INICIAL, PROX_RODADA, ACERTO, ERRO, TIMEOUT: w_rd_addr = '0;
      MOSTRA_APAGADO:
        if (r_timer == LED_FIM) w_rd_addr = w_ha_mais ? w_addr_inc[AW-1:0] : '0;
      default: w_rd_addr = r_addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset && r_estado == GRAVA_ESCREVE) r_mem[r_ptr] <= r_cap;
    r_dout <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado      <= INICIAL;
      r_ptr         <= '0;
      r_addr        <= '0;
      r_timer       <= '0;
      r_comprimento <= '0;
      r_rodada      <= '0;
      r_or_prev     <= 1'b0;
      r_press       <= 1'b0;
      r_cap         <= '0;
      r_conf_pend   <= 1'b0;
    end else begin
      r_or_prev <= |botoes;
      r_press   <= w_rise;
      if (w_rise) r_cap <= botoes;

      case (r_estado)
        INICIAL, ACERTO, ERRO, TIMEOUT: begin
          if (gravar) begin
            r_estado      <= GRAVA_ESPERA;
            r_ptr         <= '0;
            r_comprimento <= '0;
            r_conf_pend   <= 1'b0;
          end else if (jogar && r_comprimento != '0) begin
            r_estado <= MOSTRA_ACESO;
            r_rodada <= w_rodada0;
            r_addr   <= '0;
            r_timer  <= '0;
          end
        end
        GRAVA_ESPERA: begin
          if (r_press && w_onehot) begin
            r_estado    <= GRAVA_ESCREVE;
            r_conf_pend <= confirma;
          end else if (confirma) begin
            r_estado <= INICIAL;
          end
        end
        GRAVA_ESCREVE: begin
          r_ptr         <= w_ptr_inc[AW-1:0];
          r_comprimento <= w_ptr_inc;
          r_conf_pend   <= 1'b0;
          if (r_conf_pend || confirma || w_ptr_inc == (AW+1)'(PROF)) r_estado <= INICIAL;
          else r_estado <= GRAVA_ESPERA;
        end
        MOSTRA_ACESO: begin
          if (r_timer == LED_FIM) begin
            r_timer  <= '0;
            r_estado <= MOSTRA_APAGADO;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        MOSTRA_APAGADO: begin
          if (r_timer == LED_FIM) begin
            r_timer <= '0;
            if (w_ha_mais) begin
              r_addr   <= w_addr_inc[AW-1:0];
              r_estado <= MOSTRA_ACESO;
            end else begin
              r_addr   <= '0;
              r_estado <= ESPERA_JOGADA;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ESPERA_JOGADA: begin
          if (r_press) begin
            r_timer  <= '0;
            r_estado <= COMPARA;
          end else if (r_timer == JOG_FIM) begin
            r_timer  <= '0;
            r_estado <= TIMEOUT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        COMPARA: begin
          if (r_cap != r_dout) begin
            r_estado <= ERRO;
          end else if (w_ha_mais) begin
            r_addr   <= w_addr_inc[AW-1:0];
            r_timer  <= '0;
            r_estado <= ESPERA_JOGADA;
          end else if (r_rodada == r_comprimento) begin
            r_estado <= ACERTO;
          end else begin
            r_estado <= PROX_RODADA;
          end
        end
        PROX_RODADA: begin
          r_rodada <= r_rodada + (AW+1)'(1);
          r_addr   <= '0;
          r_timer  <= '0;
          r_estado <= MOSTRA_ACESO;
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    case (r_estado)
      MOSTRA_ACESO:  leds = r_dout;
      ESPERA_JOGADA: leds = botoes;
      default:       leds = '0;
    endcase
  end

  assign pronto      = (r_estado == INICIAL);
  assign acertou     = (r_estado == ACERTO);
  assign errou       = (r_estado == ERRO);
  assign timeout     = (r_estado == TIMEOUT);
  assign comprimento = r_comprimento;
  assign rodada      = r_rodada;
  assign db_estado   = r_estado;
  assign db_endereco = r_addr;

endmodule

// File: tb/tb_playseq_motor_sequencia.sv
// tb/tb_playseq_motor_sequencia.sv - scoreboard bench for playseq_motor_sequencia
module tb_playseq_motor_sequencia;

  localparam int N      = 4;
  localparam int PROF   = 8;
  localparam int AW     = 3;
  localparam int T_LED  = 4;
  localparam int T_JOG  = 20;

  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_GESPERA  = 4'd1;
  localparam logic [3:0] S_ACESO    = 4'd3;
  localparam logic [3:0] S_APAGADO  = 4'd4;
  localparam logic [3:0] S_ESPERA   = 4'd5;
  localparam logic [3:0] S_COMPARA  = 4'd6;
  localparam logic [3:0] S_ERRO     = 4'd9;
  localparam logic [3:0] S_TIMEOUT  = 4'd10;

  logic          clock = 1'b0;
  logic          reset, gravar, confirma, jogar;
  logic [AW:0]   inicio;
  logic [N-1:0]  botoes;
  logic [N-1:0]  leds;
  logic          pronto, acertou, errou, timeout;
  logic [AW:0]   comprimento, rodada;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_endereco;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] seq [PROF];
  logic [N-1:0] q_exp [$];

  playseq_motor_sequencia #(
    .N_BOTOES(N), .PROF(PROF), .T_LED(T_LED), .T_JOGADA(T_JOG)
  ) dut (
    .clock(clock), .reset(reset), .gravar(gravar), .confirma(confirma),
    .jogar(jogar), .inicio(inicio), .botoes(botoes), .leds(leds),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .comprimento(comprimento), .rodada(rodada), .db_estado(db_estado),
    .db_endereco(db_endereco)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [N-1:0] v);
    botoes = v;
    tick();
    tick();
    botoes = '0;
    tick();
  endtask

  task automatic show_round(input int r);
    for (int i = 0; i < r; i++) q_exp.push_back(seq[i]);
    for (int i = 0; i < r; i++) begin
      int wait_n = 0;
      int n_on = 0;
      int n_off = 0;
      logic [N-1:0] exp_v;
      while (db_estado !== S_ACESO && wait_n < 50) begin tick(); wait_n++; end
      exp_v = q_exp.pop_front();
      n_tests++;
      if (leds !== exp_v) begin
        n_fail++;
        $display("FAIL show_led r%0d s%0d: leds=%b expected %b", r, i, leds, exp_v);
      end
      while (db_estado === S_ACESO && leds === exp_v && n_on < 50) begin n_on++; tick(); end
      n_tests++;
      if (n_on != T_LED) begin
        n_fail++;
        $display("FAIL show_lit_len r%0d s%0d: %0d cycles expected %0d", r, i, n_on, T_LED);
      end
      while (db_estado === S_APAGADO && leds === '0 && n_off < 50) begin n_off++; tick(); end
      n_tests++;
      if (n_off != T_LED) begin
        n_fail++;
        $display("FAIL show_dark_len r%0d s%0d: %0d cycles expected %0d", r, i, n_off, T_LED);
      end
    end
    n_tests++;
    if (db_estado !== S_ESPERA) begin
      n_fail++;
      $display("FAIL show_end_state r%0d: state=%0d expected %0d", r, db_estado, S_ESPERA);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({pronto, acertou, errou, timeout} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_status: %b expected 1000", {pronto, acertou, errou, timeout});
    end
    n_tests++;
    if (leds !== '0 || comprimento !== '0 || rodada !== '0 || db_endereco !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: leds=%b comp=%0d rod=%0d addr=%0d expected all 0",
               leds, comprimento, rodada, db_endereco);
    end
  endtask

  task automatic test_record();
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b1000;
    gravar = 1'b1; tick(); gravar = 1'b0;
    n_tests++;
    if (db_estado !== S_GESPERA) begin
      n_fail++;
      $display("FAIL record_enter: state=%0d expected %0d", db_estado, S_GESPERA);
    end
    press(4'b0001);
    press(4'b0100);
    press(4'b0011);
    n_tests++;
    if (comprimento !== 2) begin
      n_fail++;
      $display("FAIL record_reject: comprimento=%0d expected 2", comprimento);
    end
    press(4'b1000);
    confirma = 1'b1; tick(); confirma = 1'b0;
    n_tests++;
    if (db_estado !== S_INICIAL || comprimento !== 3) begin
      n_fail++;
      $display("FAIL record_done: state=%0d comp=%0d expected 0 and 3", db_estado, comprimento);
    end
  endtask

  task automatic test_game_correct();
    inicio = 1; jogar = 1'b1; tick(); jogar = 1'b0;
    n_tests++;
    if (rodada !== 1) begin
      n_fail++;
      $display("FAIL game_rodada0: rodada=%0d expected 1", rodada);
    end
    for (int r = 1; r <= 3; r++) begin
      show_round(r);
      for (int i = 0; i < r; i++) press(seq[i]);
    end
    n_tests++;
    if (acertou !== 1'b1 || rodada !== 3 || leds !== '0) begin
      n_fail++;
      $display("FAIL game_acerto: acertou=%b rodada=%0d leds=%b expected 1 3 0000", acertou, rodada, leds);
    end
  endtask

  task automatic test_error();
    inicio = 0; jogar = 1'b1; tick(); jogar = 1'b0;
    n_tests++;
    if (rodada !== 1) begin
      n_fail++;
      $display("FAIL error_inicio0: rodada=%0d expected 1", rodada);
    end
    show_round(1);
    press(seq[0]);
    show_round(2);
    press(seq[0]);
    press(4'b0010);
    n_tests++;
    if (errou !== 1'b1 || leds !== '0 || db_estado !== S_ERRO) begin
      n_fail++;
      $display("FAIL error_flag: errou=%b leds=%b state=%0d expected 1 0000 %0d", errou, leds, db_estado, S_ERRO);
    end
    repeat (10) tick();
    n_tests++;
    if (errou !== 1'b1) begin
      n_fail++;
      $display("FAIL error_hold: errou=%b expected 1", errou);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    inicio = 1; jogar = 1'b1; tick(); jogar = 1'b0;
    n_tests++;
    if (errou !== 1'b0 || db_estado !== S_ACESO) begin
      n_fail++;
      $display("FAIL timeout_restart: errou=%b state=%0d expected 0 %0d", errou, db_estado, S_ACESO);
    end
    show_round(1);
    while (timeout !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++;
    if (n != T_JOG || db_estado !== S_TIMEOUT || leds !== '0) begin
      n_fail++;
      $display("FAIL timeout_len: %0d cycles state=%0d leds=%b expected %0d %0d 0000",
               n, db_estado, leds, T_JOG, S_TIMEOUT);
    end
    jogar = 1'b1; tick(); jogar = 1'b0;
    show_round(1);
    repeat (T_JOG - 2) tick();
    botoes = seq[0];
    tick();
    tick();
    botoes = '0;
    n_tests++;
    if (db_estado !== S_COMPARA || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_last_press: state=%0d timeout=%b expected %0d 0", db_estado, timeout, S_COMPARA);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (db_estado !== S_ACESO && n < 20) begin tick(); n++; end
    n_tests++;
    if (db_estado !== S_ACESO) begin
      n_fail++;
      $display("FAIL mid_reach_show: state=%0d expected %0d", db_estado, S_ACESO);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++;
    if (pronto !== 1'b1 || leds !== '0 || comprimento !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: pronto=%b leds=%b comp=%0d expected 1 0000 0", pronto, leds, comprimento);
    end
    jogar = 1'b1; tick(); jogar = 1'b0; tick();
    n_tests++;
    if (db_estado !== S_INICIAL || rodada !== '0) begin
      n_fail++;
      $display("FAIL mid_jogar_ignored: state=%0d rodada=%0d expected 0 0", db_estado, rodada);
    end
  endtask

  task automatic test_full_record();
    for (int i = 0; i < PROF; i++) seq[i] = N'(1) << (i % N);
    gravar = 1'b1; tick(); gravar = 1'b0;
    for (int i = 0; i < PROF; i++) press(seq[i]);
    n_tests++;
    if (db_estado !== S_INICIAL || comprimento !== PROF) begin
      n_fail++;
      $display("FAIL full_autoexit: state=%0d comp=%0d expected 0 %0d", db_estado, comprimento, PROF);
    end
    inicio = PROF + 5; jogar = 1'b1; tick(); jogar = 1'b0;
    n_tests++;
    if (rodada !== PROF) begin
      n_fail++;
      $display("FAIL full_clamp: rodada=%0d expected %0d", rodada, PROF);
    end
    show_round(PROF);
  endtask

  initial begin
    reset = 1'b1; gravar = 1'b0; confirma = 1'b0; jogar = 1'b0;
    inicio = '0; botoes = '0;
    tick();
    test_reset();
    test_record();
    test_game_correct();
    test_error();
    test_timeout();
    test_reset_mid();
    test_full_record();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
